// File: rtl/serializer.sv
// rtl/serializer.sv - parallel-to-serial converter, one WIDTH-bit word every WIDTH bit-clock cycles
module serializer #(
    parameter int WIDTH     = 10,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] data,
    output logic             data_req,
    output logic             serialized,
    output logic             word_start
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic             load;
    logic             first_bit;
    logic             next_bit;

    // A load happens on the enabled edge that closes the current frame.
    assign load     = en && (cnt == LAST);
    assign data_req = rst && load;

    // First bit is taken from live data on the load edge; later bits come
    // from the captured copy only, so data may change freely between loads.
    assign first_bit = MSB_FIRST ? data[WIDTH-1] : data[0];
    assign next_bit  = MSB_FIRST ? shreg[WIDTH-2] : shreg[1];

    // Frame counter, captured word and registered serial outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= LAST;
            shreg      <= '0;
            serialized <= 1'b0;
            word_start <= 1'b0;
        end else if (!en) begin
            cnt        <= LAST;
            serialized <= 1'b0;
            word_start <= 1'b0;
        end else if (load) begin
            cnt        <= '0;
            shreg      <= data;
            serialized <= first_bit;
            word_start <= 1'b1;
        end else begin
            cnt        <= cnt + CW'(1);
            serialized <= next_bit;
            word_start <= 1'b0;
            // Rotate so the next bit to send always sits in the same position.
            shreg      <= MSB_FIRST ? {shreg[WIDTH-2:0], shreg[WIDTH-1]}
                                    : {shreg[0], shreg[WIDTH-1:1]};
        end
    end

endmodule

// File: tb/tb_serializer.sv
// tb/tb_serializer.sv - table-driven self-checking bench for serializer
module tb_serializer;

    localparam int W = 10;

    logic         clk;
    logic         rst;
    logic         en;
    logic [W-1:0] data;
    logic         req_l, ser_l, ws_l;
    logic         req_m, ser_m, ws_m;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         en;
        logic [W-1:0] data;
        logic         req;
        logic         ser;
        logic         ws;
        logic         ser_msb;
    } vec_t;

    vec_t vecs[$];

    serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .en(en), .data(data),
        .data_req(req_l), .serialized(ser_l), .word_start(ws_l)
    );

    serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .en(en), .data(data),
        .data_req(req_m), .serialized(ser_m), .word_start(ws_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One full word: load row with the real word, then rows with garbage on data.
    task automatic add_word(input logic [W-1:0] word);
        vec_t v;
        for (int k = 0; k < W; k++) begin
            v.en      = 1'b1;
            v.data    = (k == 0) ? word : (word ^ W'(10'h0A3 + 37 * k));
            v.req     = (k == 0);
            v.ser     = word[k];
            v.ws      = (k == 0);
            v.ser_msb = word[W-1-k];
            vecs.push_back(v);
        end
    endtask

    task automatic add_partial(input logic [W-1:0] word, input int nbits);
        vec_t v;
        for (int k = 0; k < nbits; k++) begin
            v.en      = 1'b1;
            v.data    = (k == 0) ? word : ~word;
            v.req     = (k == 0);
            v.ser     = word[k];
            v.ws      = (k == 0);
            v.ser_msb = word[W-1-k];
            vecs.push_back(v);
        end
    endtask

    task automatic add_idle();
        vec_t v;
        v.en = 1'b0; v.data = 10'h3C3; v.req = 1'b0;
        v.ser = 1'b0; v.ws = 1'b0; v.ser_msb = 1'b0;
        vecs.push_back(v);
    endtask

    initial begin
        logic [W-1:0] w;

        add_word(10'h2A5);
        add_word(10'h3FF);
        add_word(10'h000);
        add_partial(10'h155, 4);
        add_idle();
        add_idle();
        add_word(10'h2A5);

        rst  = 1'b0;
        en   = 1'b0;
        data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ser", ser_l, 0);
        chk("reset_ws", ws_l, 0);
        chk("reset_req", req_l, 0);
        chk("reset_ser_msb", ser_m, 0);

        rst = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            en   = vecs[i].en;
            data = vecs[i].data;
            #1;
            chk($sformatf("req[%0d]", i), req_l, vecs[i].req);
            chk($sformatf("req_msb[%0d]", i), req_m, vecs[i].req);
            @(posedge clk);
            #1;
            chk($sformatf("ser[%0d]", i), ser_l, vecs[i].ser);
            chk($sformatf("ws[%0d]", i), ws_l, vecs[i].ws);
            chk($sformatf("ser_msb[%0d]", i), ser_m, vecs[i].ser_msb);
            chk($sformatf("ws_msb[%0d]", i), ws_m, vecs[i].ws);
        end

        // Asynchronous reset in the middle of bit 6 of an all-ones word.
        en   = 1'b1;
        data = 10'h3FF;
        @(posedge clk);
        #1;
        chk("arst_load_ws", ws_l, 1);
        data = 10'h000;
        repeat (6) @(posedge clk);
        #1;
        chk("arst_bit6_ser", ser_l, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_ser_async", ser_l, 0);
        chk("arst_ser_msb_async", ser_m, 0);
        chk("arst_ws_async", ws_l, 0);
        chk("arst_req", req_l, 0);
        @(posedge clk);
        #2;
        rst  = 1'b1;
        w    = 10'h2A5;
        data = w;
        #1;
        chk("arst_release_req", req_l, 1);
        @(posedge clk);
        #1;
        chk("arst_reload_ws", ws_l, 1);
        chk("arst_reload_bit0", ser_l, w[0]);
        data = 10'h1C7;
        for (int k = 1; k < W; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("arst_bit%0d", k), ser_l, w[k]);
            chk($sformatf("arst_ws%0d", k), ws_l, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
